rr_mux_4: RTL and testbench

Registered 4-input round-robin arbiter with valid/ready handshakes that sits directly upstream of the 4:1 select path. It picks one of four requesting sources fairly, drives the 2-bit select of an internal `mux_4`, and registers the selected word plus its source index into a one-entry output stage. Downstream logic consumes `o_data`/`o_sel` through a valid/ready handshake.

---
 rtl/rr_mux_pkg.sv | 32 +++
 rtl/mux_4.sv | 27 ++
 rtl/rr_mux_4.sv | 100 ++++++++++
 tb/tb_rr_mux_4.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and constants for the round-robin 4:1 arbiter.
//   sel_t    : 2-bit source index
//   state_t  : output-stage occupancy (EMPTY / FULL)
//   N_SRC    : number of sources
//   CNT_W    : width of each per-source grant counter
//   rr_pick  : first valid source scanning from a start pointer, wrapping 3 -> 0
package rr_mux_pkg;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int N_SRC = 4;
    localparam int CNT_W = 8;

    // Rotate the request vector so the pointer position lands at bit 0,
    // take the lowest set bit, then rotate the offset back.
    function automatic sel_t rr_pick(input logic [N_SRC-1:0] v, input sel_t ptr);
        logic [2*N_SRC-1:0] dbl;
        sel_t               off;
        dbl = {v, v} >> ptr;
        off = 2'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (dbl[k]) off = sel_t'(k);
        end
        return sel_t'(ptr + off);
    endfunction

endpackage

// File: rtl/mux_4.sv
// mux_4: plain combinational 4:1 word selector.
//   i_s      : select index
//   i_in0..3 : candidate words
//   o_y      : selected word
module mux_4
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  sel_t             i_s,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [WIDTH-1:0] i_in3,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        case (i_s)
            2'd0:    o_y = i_in0;
            2'd1:    o_y = i_in1;
            2'd2:    o_y = i_in2;
            default: o_y = i_in3;
        endcase
    end

endmodule

// File: rtl/rr_mux_4.sv
// rr_mux_4: registered 4-source round-robin arbiter feeding a 4:1 select,
// with a one-entry valid/ready output stage.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_valid[3:0] : per-source request
//   i_in0..i_in3 : per-source data words
//   o_ready[3:0] : one-hot grant, source word taken this cycle
//   o_valid      : output stage holds a word
//   o_data       : registered winning word
//   o_sel        : index of the source that produced o_data
//   i_ready      : downstream accepts o_data when o_valid && i_ready
//   o_cnt[31:0]  : per-source saturating grant counters, only when
//                  RR_MUX_4_CNT_EN is defined (source k in bits [8k+7:8k])
module rr_mux_4
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_valid,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [WIDTH-1:0] i_in3,
    output logic [3:0]       o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output sel_t             o_sel,
    input  logic             i_ready
`ifdef RR_MUX_4_CNT_EN
    ,
    output logic [31:0]      o_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    sel_t             r_ptr;
    sel_t             r_sel;
    logic [WIDTH-1:0] r_data;
    sel_t             w_win;
    logic             w_load;
    logic [WIDTH-1:0] w_mux;

    mux_4 #(.WIDTH(WIDTH)) u_mux (
        .i_s   (w_win),
        .i_in0 (i_in0),
        .i_in1 (i_in1),
        .i_in2 (i_in2),
        .i_in3 (i_in3),
        .o_y   (w_mux)
    );

    // Grant is suppressed during reset so no source believes its word was
    // taken while the stage is being cleared.
    always_comb begin
        w_win       = rr_pick(i_valid, r_ptr);
        w_load      = !i_rst && ((r_state == EMPTY) || i_ready) && (|i_valid);
        o_ready     = w_load ? (4'b0001 << w_win) : 4'b0000;
        w_state_nxt = r_state;
        if (w_load)
            w_state_nxt = FULL;
        else if ((r_state == FULL) && i_ready)
            w_state_nxt = EMPTY;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data <= w_mux;
                r_sel  <= w_win;
                r_ptr  <= sel_t'(w_win + 2'd1);
            end
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;
    assign o_sel   = r_sel;

`ifdef RR_MUX_4_CNT_EN
    for (genvar k = 0; k < N_SRC; k++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge i_clk) begin
            if (i_rst)
                r_cnt <= '0;
            else if (o_ready[k] && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
        assign o_cnt[CNT_W*k +: CNT_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_rr_mux_4.sv
module tb_rr_mux_4;
    import rr_mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid;
    logic [3:0] d [4];
    logic [3:0] ready_o;
    logic       ovalid;
    logic [3:0] odata;
    sel_t       osel;
    logic       rdy;
`ifdef RR_MUX_4_CNT_EN
    logic [31:0] ocnt;
`endif

    always #5 clk = ~clk;

    rr_mux_4 #(.WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_in0   (d[0]),
        .i_in1   (d[1]),
        .i_in2   (d[2]),
        .i_in3   (d[3]),
        .o_ready (ready_o),
        .o_valid (ovalid),
        .o_data  (odata),
        .o_sel   (osel),
        .i_ready (rdy)
`ifdef RR_MUX_4_CNT_EN
        ,
        .o_cnt   (ocnt)
`endif
    );

    // Behavioural model state
    int         m_valid, m_sel, m_ptr;
    logic [3:0] m_data;
    int         m_cnt [4];
    logic [3:0] last_ready;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_sel = 0; m_ptr = 0; m_data = 4'd0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    // One clock cycle: apply inputs, compare every DUT output with the model
    // mid-cycle, advance the model, then step past the rising edge.
    task automatic cyc(input logic [3:0] v, input logic r, input logic rs);
        int         win;
        logic       load;
        logic [3:0] er;
        valid = v; rdy = r; rst = rs;
        @(negedge clk);
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        load = !rs && (m_valid == 0 || r) && (v != 4'd0);
        er = load ? 4'(1 << win) : 4'd0;
        last_ready = ready_o;
        chk("o_ready", 32'(ready_o), 32'(er));
        chk("o_valid", 32'(ovalid), 32'(m_valid));
        chk("o_data",  32'(odata),  32'(m_data));
        chk("o_sel",   32'(osel),   32'(m_sel));
`ifdef RR_MUX_4_CNT_EN
        chk("o_cnt", ocnt, {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]});
`endif
        if (rs) model_reset();
        else if (load) begin
            m_data  = d[win];
            m_sel   = win;
            m_valid = 1;
            m_ptr   = (win + 1) % 4;
            if (m_cnt[win] < 255) m_cnt[win]++;
        end else if (m_valid == 1 && r) m_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic v, input logic [3:0] dat, input int s);
        chk({nm, " valid"}, 32'(ovalid), 32'(v));
        chk({nm, " data"},  32'(odata),  32'(dat));
        chk({nm, " sel"},   32'(osel),   32'(s));
    endtask

    initial begin
        logic [3:0] exp_d [5];
        int         exp_s [5];
        model_reset();
        last_ready = 4'd0;
        valid = 4'd0; rdy = 1'b1; rst = 1'b1;
        d[0] = 4'b1111; d[1] = 4'b0000; d[2] = 4'b0011; d[3] = 4'b0101;

        // 1: reset, single request from source 0
        cyc(4'b0000, 1'b1, 1'b1);
        chk("rst o_ready", 32'(last_ready), 32'd0);
        lit("rst", 1'b0, 4'b0000, 0);
        cyc(4'b0001, 1'b1, 1'b0);
        chk("s1 o_ready", 32'(last_ready), 32'b0001);
        lit("s1", 1'b1, 4'b1111, 0);

        // 2: all valid from a fresh pointer, full rotation
        cyc(4'b0000, 1'b1, 1'b1);
        exp_d = '{4'b1111, 4'b0000, 4'b0011, 4'b0101, 4'b1111};
        exp_s = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b1, 1'b0);
            lit("s2", 1'b1, exp_d[i], exp_s[i]);
        end

        // 3: grant 3, then alternating 1/3 with wrap
        cyc(4'b1000, 1'b1, 1'b0);
        lit("s3 g3", 1'b1, 4'b0101, 3);
        cyc(4'b1010, 1'b1, 1'b0);
        lit("s3a", 1'b1, 4'b0000, 1);
        cyc(4'b1010, 1'b1, 1'b0);
        lit("s3b", 1'b1, 4'b0101, 3);
        cyc(4'b1010, 1'b1, 1'b0);
        lit("s3c", 1'b1, 4'b0000, 1);

        // 4: stall while FULL
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 1'b0, 1'b0);
            chk("s4 stall o_ready", 32'(last_ready), 32'd0);
            lit("s4 stall", 1'b1, 4'b0000, 1);
        end
        cyc(4'b0100, 1'b1, 1'b0);
        chk("s4 o_ready", 32'(last_ready), 32'b0100);
        lit("s4", 1'b1, 4'b0011, 2);

        // 5: reset while FULL with 0101
        cyc(4'b1000, 1'b1, 1'b0);
        lit("s5 pre", 1'b1, 4'b0101, 3);
        cyc(4'b1111, 1'b1, 1'b1);
        chk("s5 rst o_ready", 32'(last_ready), 32'd0);
        lit("s5 rst", 1'b0, 4'b0000, 0);
        cyc(4'b1111, 1'b1, 1'b0);
        chk("s5 o_ready", 32'(last_ready), 32'b0001);
        lit("s5", 1'b1, 4'b1111, 0);

        // drain: no requests, accept -> empty, data holds
        cyc(4'b0000, 1'b1, 1'b0);
        lit("drain", 1'b0, 4'b1111, 0);

`ifdef RR_MUX_4_CNT_EN
        // 6: saturating counter on source 2
        cyc(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) cyc(4'b0100, 1'b1, 1'b0);
        chk("s6 cnt", ocnt, 32'h00FF_0000);
`endif

        // randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) d[k] = 4'($urandom);
            cyc(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
